// File: rtl/fetch_pc_fd_reg_pkg.sv
// Shared constants for the fetch stage: reset/exception addresses, text segment
// bounds, CP0 exception codes and the F/D pipeline register layout.
package fetch_pc_fd_reg_pkg;

  localparam logic [31:0] PC_RESET     = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] TEXT_LO_ADDR = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI_ADDR = 32'h0000_6ffc;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // CP0 ExcCode values; Int shares the zero encoding with "no exception".
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc_code;
    logic        bd;
  } fd_reg_t;

  // D-stage contents after reset, flush or squash: a nop with no exception.
  function automatic fd_reg_t fd_bubble(input logic [31:0] pc);
    fd_reg_t r;
    r.pc       = pc;
    r.instr    = NOP_INSTR;
    r.exc_code = EXC_NONE;
    r.bd       = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/fetch_addr_check.sv
// Fetch address error (AdEL) detection: misaligned or outside the text segment.
module fetch_addr_check
  import fetch_pc_fd_reg_pkg::*;
#(
  parameter logic [31:0] TEXT_LO = TEXT_LO_ADDR,
  parameter logic [31:0] TEXT_HI = TEXT_HI_ADDR
) (
  input  logic [31:0] F_PC,
  output logic        F_adel
);

  assign F_adel = (F_PC[1:0] != 2'b00) || (F_PC < TEXT_LO) || (F_PC > TEXT_HI);

endmodule

// File: rtl/fetch_pc_fd_reg.sv
// Fetch PC register plus F/D pipeline register: stall, exception redirect,
// eret squash, AdEL tagging and branch-delay-slot marking.
module fetch_pc_fd_reg
  import fetch_pc_fd_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PC_RESET,
  parameter logic [31:0] EXC_ENTRY = PC_EXC_ENTRY,
  parameter logic [31:0] TEXT_LO   = TEXT_LO_ADDR,
  parameter logic [31:0] TEXT_HI   = TEXT_HI_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_NPC,
  input  logic        stall,
  input  logic        req,
  input  logic        D_isBranchJump,
  input  logic        D_isEret,
  input  logic [31:0] F_instr_in,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic [4:0]  D_excCode,
  output logic        D_BD
);

  logic [31:0] pc_q, pc_d;
  fd_reg_t     fd_q, fd_d;
  logic        f_adel;

  fetch_addr_check #(
    .TEXT_LO(TEXT_LO),
    .TEXT_HI(TEXT_HI)
  ) u_addr_check (
    .F_PC  (pc_q),
    .F_adel(f_adel)
  );

  always_comb begin
    // NOTE: hold values are assigned first so every path drives pc_d/fd_d and no latch is inferred.
    pc_d = pc_q;
    fd_d = fd_q;
    if (req) begin
      pc_d = EXC_ENTRY;
      fd_d = fd_bubble(EXC_ENTRY);
    end else if (!stall) begin
      pc_d = F_NPC;
      if (D_isEret) begin
        // eret has no delay slot: the instruction fetched behind it never decodes.
        fd_d = fd_bubble(pc_q);
      end else begin
        // A faulting fetch still advances; the nop carries AdEL with the bad PC as EPC source.
        fd_d.pc       = pc_q;
        fd_d.instr    = f_adel ? NOP_INSTR : F_instr_in;
        fd_d.exc_code = f_adel ? EXC_ADEL : EXC_NONE;
        fd_d.bd       = D_isBranchJump;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      fd_q <= fd_bubble(32'h0);
    end else begin
      pc_q <= pc_d;
      fd_q <= fd_d;
    end
  end

  assign F_PC      = pc_q;
  assign D_PC      = fd_q.pc;
  assign D_instr   = fd_q.instr;
  assign D_excCode = fd_q.exc_code;
  assign D_BD      = fd_q.bd;

endmodule

// File: tb/tb_fetch_pc_fd_reg.sv
// Scoreboard bench for fetch_pc_fd_reg: directed vectors push expected post-edge
// state into a queue; a negedge monitor pops and compares.
module tb_fetch_pc_fd_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_NPC;
  logic        stall;
  logic        req;
  logic        D_isBranchJump;
  logic        D_isEret;
  logic [31:0] F_instr_in;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic [4:0]  D_excCode;
  logic        D_BD;

  typedef struct {
    string       name;
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [4:0]  d_exc;
    logic        d_bd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fetch_pc_fd_reg dut (
    .clk           (clk),
    .reset         (reset),
    .F_NPC         (F_NPC),
    .stall         (stall),
    .req           (req),
    .D_isBranchJump(D_isBranchJump),
    .D_isEret      (D_isEret),
    .F_instr_in    (F_instr_in),
    .F_PC          (F_PC),
    .D_PC          (D_PC),
    .D_instr       (D_instr),
    .D_excCode     (D_excCode),
    .D_BD          (D_BD)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Monitor: every cycle the DUT presents a new register state.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".F_PC"},      F_PC,              e.f_pc);
      check({e.name, ".D_PC"},      D_PC,              e.d_pc);
      check({e.name, ".D_instr"},   D_instr,           e.d_instr);
      check({e.name, ".D_excCode"}, {27'h0, D_excCode}, {27'h0, e.d_exc});
      check({e.name, ".D_BD"},      {31'h0, D_BD},      {31'h0, e.d_bd});
    end
  end

  // Apply inputs for one edge, then queue the expected post-edge state.
  task automatic step(
    input string       name,
    input logic        rst,
    input logic        stl,
    input logic        rq,
    input logic        bj,
    input logic        eret,
    input logic [31:0] npc,
    input logic [31:0] instr,
    input logic [31:0] e_fpc,
    input logic [31:0] e_dpc,
    input logic [31:0] e_instr,
    input logic [4:0]  e_exc,
    input logic        e_bd
  );
    exp_t e;
    #1;
    reset          = rst;
    stall          = stl;
    req            = rq;
    D_isBranchJump = bj;
    D_isEret       = eret;
    F_NPC          = npc;
    F_instr_in     = instr;
    @(posedge clk);
    e.name    = name;
    e.f_pc    = e_fpc;
    e.d_pc    = e_dpc;
    e.d_instr = e_instr;
    e.d_exc   = e_exc;
    e.d_bd    = e_bd;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; req = 1'b0; D_isBranchJump = 1'b0; D_isEret = 1'b0;
    F_NPC = 32'h0; F_instr_in = 32'h0;

    //    name          rst stl rq bj er  F_NPC         F_instr_in    F_PC          D_PC          D_instr       exc   bd
    step("reset",       1, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_3000, 32'h0000_0000, 32'h0000_0000, 5'd0, 0);
    step("reset_win",   1, 1, 1, 1, 1, 32'h0000_5555, 32'h1234_5678, 32'h0000_3000, 32'h0000_0000, 32'h0000_0000, 5'd0, 0);
    step("run0",        0, 0, 0, 0, 0, 32'h0000_3004, 32'h2401_0001, 32'h0000_3004, 32'h0000_3000, 32'h2401_0001, 5'd0, 0);
    step("run1",        0, 0, 0, 0, 0, 32'h0000_3008, 32'h2402_0002, 32'h0000_3008, 32'h0000_3004, 32'h2402_0002, 5'd0, 0);
    step("stall0",      0, 1, 0, 0, 0, 32'h0000_300c, 32'hdead_beef, 32'h0000_3008, 32'h0000_3004, 32'h2402_0002, 5'd0, 0);
    step("stall1",      0, 1, 0, 1, 1, 32'h0000_300c, 32'hdead_beef, 32'h0000_3008, 32'h0000_3004, 32'h2402_0002, 5'd0, 0);
    step("unstall",     0, 0, 0, 0, 0, 32'h0000_300c, 32'h2403_0003, 32'h0000_300c, 32'h0000_3008, 32'h2403_0003, 5'd0, 0);
    step("bd_set",      0, 0, 0, 1, 0, 32'h0000_3010, 32'h1000_0004, 32'h0000_3010, 32'h0000_300c, 32'h1000_0004, 5'd0, 1);
    step("bd_clear",    0, 0, 0, 0, 0, 32'h0000_3002, 32'h2404_0004, 32'h0000_3002, 32'h0000_3010, 32'h2404_0004, 5'd0, 0);
    step("adel_mis",    0, 0, 0, 0, 0, 32'h0000_2000, 32'hffff_ffff, 32'h0000_2000, 32'h0000_3002, 32'h0000_0000, 5'd4, 0);
    step("adel_low",    0, 0, 0, 1, 0, 32'h0000_7000, 32'hffff_ffff, 32'h0000_7000, 32'h0000_2000, 32'h0000_0000, 5'd4, 1);
    step("adel_high",   0, 0, 0, 0, 0, 32'h0000_6ffc, 32'haaaa_aaaa, 32'h0000_6ffc, 32'h0000_7000, 32'h0000_0000, 5'd4, 0);
    step("text_hi_ok",  0, 0, 0, 1, 0, 32'h0000_3010, 32'h2405_0005, 32'h0000_3010, 32'h0000_6ffc, 32'h2405_0005, 5'd0, 1);
    step("req_stall",   0, 1, 1, 1, 0, 32'h0000_3014, 32'h2406_0006, 32'h0000_4180, 32'h0000_4180, 32'h0000_0000, 5'd0, 0);
    step("handler",     0, 0, 0, 0, 0, 32'h0000_4200, 32'h2407_0007, 32'h0000_4200, 32'h0000_4180, 32'h2407_0007, 5'd0, 0);
    step("eret_squash", 0, 0, 0, 1, 1, 32'h0000_3020, 32'h2408_0008, 32'h0000_3020, 32'h0000_4200, 32'h0000_0000, 5'd0, 0);
    step("after_eret",  0, 0, 0, 0, 0, 32'h0000_3024, 32'h2409_0009, 32'h0000_3024, 32'h0000_3020, 32'h2409_0009, 5'd0, 0);
    step("eret_stall",  0, 1, 0, 0, 1, 32'h0000_3100, 32'h240a_000a, 32'h0000_3024, 32'h0000_3020, 32'h2409_0009, 5'd0, 0);
    step("reset_mid",   1, 1, 0, 0, 0, 32'h0000_3100, 32'h240a_000a, 32'h0000_3000, 32'h0000_0000, 32'h0000_0000, 5'd0, 0);

    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
        @(posedge clk);
        budget++;
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_fd_reg.md
Name: fetch_pc_fd_reg

Overview:
- Fetch-stage program counter register plus the F/D pipeline register of the 5-stage MIPS pipeline.
- Each cycle it loads the next PC computed by the D-stage NPC logic.
- It latches the fetched instruction into D, detects fetch address errors (AdEL), marks delay-slot instructions (BD), and handles stall, exception redirect and eret squash.
- Feeds the instruction memory address, the NPC logic (F_PC, D_PC) and the D-stage decoder.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset
EXC_ENTRY, 32'h0000_4180, exception/interrupt handler entry
TEXT_LO, 32'h0000_3000, lowest legal fetch address
TEXT_HI, 32'h0000_6ffc, highest legal fetch address (inclusive)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
F_NPC  input  32  next PC from NPC logic (already includes EPC on eret)
stall  input  1  hazard stall: freeze PC and F/D register
req  input  1  exception/interrupt taken by CP0 (M stage), flush and redirect
D_isBranchJump  input  1  instruction currently in D is a branch or jump, so F holds its delay slot
D_isEret  input  1  instruction currently in D is eret (no delay slot)
F_instr_in  input  32  instruction memory read data at F_PC
F_PC  output  32  current fetch PC
D_PC  output  32  PC of instruction in D
D_instr  output  32  instruction in D (32'h0 = nop)
D_excCode  output  5  exception code carried with D instruction (0 = none, 4 = AdEL)
D_BD  output  1  D instruction is in a branch delay slot

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state updates on the rising edge of clk.
- Reset values: F_PC=RESET_PC, D_PC=0, D_instr=0, D_excCode=0, D_BD=0.
- Update priority per edge: reset > req > stall > eret squash > normal.
- F_adel (combinational, internal) is 1 when any of these holds:
  - F_PC[1:0]!=0
  - F_PC<TEXT_LO
  - F_PC>TEXT_HI (unsigned compare)
- req=1:
  - F_PC<=EXC_ENTRY.
  - D_PC<=EXC_ENTRY, D_instr<=0, D_excCode<=0, D_BD<=0.
  - Overrides stall in the same cycle.
- stall=1 (req=0): F_PC and all D_* registers hold their values.
- D_isEret=1 with stall=0 and req=0:
  - F_PC<=F_NPC.
  - D_PC<=F_PC, D_instr<=0, D_excCode<=0, D_BD<=0. The instruction after eret is squashed.
- Normal:
  - F_PC<=F_NPC, D_PC<=F_PC.
  - D_instr<=F_adel?0:F_instr_in.
  - D_excCode<=F_adel?5'd4:5'd0.
  - D_BD<=D_isBranchJump.
- A faulting PC still advances: F_PC<=F_NPC. The AdEL travels with the nop so CP0 receives the faulting D_PC as EPC source.
- Latency: an instruction presented at F_PC appears on D_* one unstalled cycle later. Stall n cycles adds n cycles.
- F_NPC is consumed only on unstalled, non-req, non-reset edges. No wrap check beyond F_adel; 32-bit add overflow in upstream logic is the caller's concern.
- Reset asserted mid-stall or mid-req wins unconditionally. On the first cycle after reset, F_PC=RESET_PC and D holds a nop.
- Outputs are register outputs only, with no combinational path from inputs to outputs.

Decomposition:
- Shared package/header: RESET_PC and EXC_ENTRY address constants, exception code constants (EXC_NONE=0, EXC_ADEL=4, alongside existing Int/AdES/RI/Ov codes), NOP encoding 32'h0.
- One sub-module is natural: fetch_addr_check (combinational F_adel from F_PC, TEXT_LO/HI). PC register and F/D register stay in the top.

Test Plan:
- Reset then release, F_NPC=F_PC+4, F_instr_in=0x24010001 -> cycle 1 F_PC=0x3000, D_instr=0; cycle 2 F_PC=0x3004, D_PC=0x3000, D_instr=0x24010001, D_excCode=0.
- stall=1 for 2 cycles with F_PC=0x3008 -> F_PC and D_PC/D_instr unchanged for both cycles; on release F_PC=F_NPC, D_PC=0x3008.
- D_isBranchJump=1 while F_PC=0x300c -> next cycle D_PC=0x300c, D_BD=1. Following cycle with D_isBranchJump=0 -> D_BD=0.
- F_NPC=0x3002 (misaligned), then F_NPC=0x0000_2000 (below TEXT_LO) -> each reaches D with D_instr=0, D_excCode=4, D_PC equal to the faulting address.
- req=1 together with stall=1 at F_PC=0x3010 -> next F_PC=0x4180, D_PC=0x4180, D_instr=0, D_BD=0.
- D_isEret=1, F_NPC=0x3020 (EPC), F_PC=0x4200 -> next F_PC=0x3020, D_instr=0, D_PC=0x4200. The instruction at 0x4200 never decodes.
